// File: rtl/accelerator_vector_feeder.sv
// accelerator_vector_feeder: streams a buffered vector element-by-element to a downstream controller with per-element handshake.
// Optional ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN adds a CHECKSUM output summing every emitted element.
module accelerator_vector_feeder #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic                 LOAD_ENABLE,
    input  logic [ADDR_SIZE-1:0] LOAD_ADDR,
    input  logic [DATA_SIZE-1:0] LOAD_DATA,
    output logic                 X_IN_ENABLE,
    output logic [DATA_SIZE-1:0] X_IN,
`ifdef ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN
    output logic [DATA_SIZE-1:0] CHECKSUM,
`endif
    input  logic                 X_OUT_ENABLE
);
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [DATA_SIZE-1:0] DEPTH_W = DATA_SIZE'(DEPTH);
    localparam logic [ADDR_SIZE:0] ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE:0]   idx_q, idx_d, size_q, size_d, idx_nx;
    logic                 ready_q, ready_d, busy_q, busy_d, error_q, error_d, xen_q, xen_d;
    logic [DATA_SIZE-1:0] xin_q, xin_d, rd_data;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 start_ok, ack, last, emit;

    assign idx_nx   = idx_q + ONE;
    assign start_ok = state_q == S_IDLE && START && SIZE_IN != '0 && SIZE_IN <= DEPTH_W;
    assign ack      = state_q == S_WAIT && X_OUT_ENABLE;
    assign last     = idx_q == size_q - ONE;
    assign emit     = start_ok || (ack && !last);
    // The element read is the one about to be presented: index 0 on start, index+1 on an ack.
    assign rd_addr  = start_ok ? '0 : idx_nx[ADDR_SIZE-1:0];
    assign rd_data  = mem_q[rd_addr];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        size_d  = size_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        xen_d   = emit;
        xin_d   = emit ? rd_data : xin_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_SEND;
                    size_d  = SIZE_IN[ADDR_SIZE:0];
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else if (START) begin
                    ready_d = SIZE_IN == '0;
                    error_d = SIZE_IN != '0;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (X_OUT_ENABLE) begin
                    state_d = last ? S_DONE : S_SEND;
                    idx_d   = last ? idx_q : idx_nx;
                    ready_d = last;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            size_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            xen_q   <= 1'b0;
            xin_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            error_q <= error_d;
            xen_q   <= xen_d;
            xin_q   <= xin_d;
        end
    end

    // Buffer survives reset so a vector loaded beforehand can be replayed.
    always_ff @(posedge CLK) begin
        if (!RST && LOAD_ENABLE && state_q == S_IDLE) mem_q[LOAD_ADDR] <= LOAD_DATA;
    end

`ifdef ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN
    logic [DATA_SIZE-1:0] cks_q, cks_d;

    assign cks_d    = (start_ok ? '0 : cks_q) + (emit ? rd_data : '0);
    assign CHECKSUM = cks_q;

    always_ff @(posedge CLK) begin
        if (RST) cks_q <= '0;
        else cks_q <= cks_d;
    end
`endif

    assign READY       = ready_q;
    assign BUSY        = busy_q;
    assign ERROR       = error_q;
    assign X_IN_ENABLE = xen_q;
    assign X_IN        = xin_q;
endmodule

// File: tb/tb_accelerator_vector_feeder.sv
// tb_accelerator_vector_feeder: randomized scoreboard bench; driver pushes expected elements/events, monitor pops on DUT outputs.
module tb_accelerator_vector_feeder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        READY, BUSY, ERROR, X_IN_ENABLE;
    logic [63:0] SIZE_IN = '0;
    logic        LOAD_ENABLE = 1'b0;
    logic [5:0]  LOAD_ADDR = '0;
    logic [63:0] LOAD_DATA = '0;
    logic [63:0] X_IN;
    logic        X_OUT_ENABLE = 1'b0;
    logic [63:0] checksum;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] ref_mem [64];
    logic [63:0] exp_x [$];
    logic [2:0]  exp_ev [$];
    logic [63:0] exp_ck [$];
    logic [63:0] last_x = '0;

    accelerator_vector_feeder #(.DATA_SIZE(64), .ADDR_SIZE(6)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY), .ERROR(ERROR),
        .SIZE_IN(SIZE_IN), .LOAD_ENABLE(LOAD_ENABLE), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
        .X_IN_ENABLE(X_IN_ENABLE), .X_IN(X_IN),
`ifdef ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN
        .CHECKSUM(checksum),
`endif
        .X_OUT_ENABLE(X_OUT_ENABLE)
    );

`ifndef ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN
    assign checksum = '0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every presented element/event must match the head of its expectation queue.
    always @(negedge CLK) begin
        if (RST) begin
            last_x = '0;
        end else begin
            if (X_IN_ENABLE) begin
                if (exp_x.size() == 0) chk("x_in_unexpected_pulse", 1, 0);
                else chk("x_in_value", X_IN, exp_x.pop_front());
                last_x = X_IN;
            end else begin
                chk("x_in_hold", X_IN, last_x);
            end
            if (READY || ERROR) begin
                if (exp_ev.size() == 0) begin
                    chk("unexpected_ready_error", {READY, ERROR}, 2'b00);
                end else begin
                    logic [2:0] ev;
                    ev = exp_ev.pop_front();
                    chk("ready_error_busy", {READY, ERROR, BUSY}, ev);
`ifdef ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN
                    if (ev == 3'b101) chk("checksum", checksum, exp_ck.pop_front());
`endif
                end
            end
        end
    end

    task automatic load(input int a, input logic [63:0] d);
        LOAD_ENABLE = 1'b1;
        LOAD_ADDR = 6'(a);
        LOAD_DATA = d;
        tick();
        LOAD_ENABLE = 1'b0;
        ref_mem[a] = d;
    endtask

    // dly < 0 picks a random ack delay per element; spur adds an ack during the pulse cycle.
    task automatic stream(input int size, input int dly, input bit spur, input bit intf);
        logic [63:0] s = '0;
        int d;
        START = 1'b1;
        SIZE_IN = 64'(size);
        if (size == 0) exp_ev.push_back(3'b100);
        else if (size > 64) exp_ev.push_back(3'b010);
        else begin
            for (int k = 0; k < size; k++) begin
                exp_x.push_back(ref_mem[k]);
                s += ref_mem[k];
            end
            exp_ev.push_back(3'b101);
            exp_ck.push_back(s);
        end
        tick();
        START = 1'b0;
        SIZE_IN = {$urandom(), $urandom()};
        if (size == 0 || size > 64) begin
            chk("reject_busy", BUSY, 0);
            chk("reject_pulse_now", {READY, ERROR}, size == 0 ? 2'b10 : 2'b01);
            tick();
            chk("reject_pulse_len", {READY, ERROR, BUSY}, 0);
            return;
        end
        for (int k = 0; k < size; k++) begin
            chk("x_en_timing", X_IN_ENABLE, 1);
            chk("busy_stream", BUSY, 1);
            X_OUT_ENABLE = spur;
            tick();
            X_OUT_ENABLE = 1'b0;
            chk("wait_no_pulse", X_IN_ENABLE, 0);
            d = dly < 0 ? int'($urandom_range(0, 3)) : dly;
            repeat (d) tick();
            if (intf) begin
                START = 1'b1;
                SIZE_IN = 64'd2;
                LOAD_ENABLE = 1'b1;
                LOAD_ADDR = 6'd1;
                LOAD_DATA = 64'd99;
                tick();
                START = 1'b0;
                LOAD_ENABLE = 1'b0;
                chk("intf_no_pulse", X_IN_ENABLE, 0);
            end
            X_OUT_ENABLE = 1'b1;
            tick();
            X_OUT_ENABLE = 1'b0;
        end
        chk("ready_timing", READY, 1);
        chk("busy_in_done", BUSY, 1);
        tick();
        chk("idle_after_done", {BUSY, READY, X_IN_ENABLE}, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_ctrl", {READY, BUSY, ERROR, X_IN_ENABLE}, 0);
        chk("reset_x_in", X_IN, 0);
        RST = 1'b0;
        tick();
        stream(0, 0, 0, 0);
        stream(65, 0, 0, 0);
        for (int a = 0; a < 64; a++) load(a, 64'(a));
        stream(64, 0, 1, 0);
        for (int a = 0; a < 4; a++) load(a, 64'(a + 5));
        stream(4, 1, 0, 0);
        stream(4, 0, 0, 1);
        stream(4, -1, 1, 0);
        // Reset in WAIT after element 2, colliding with START/LOAD/ack.
        START = 1'b1;
        SIZE_IN = 64'd4;
        exp_x.push_back(ref_mem[0]);
        exp_x.push_back(ref_mem[1]);
        tick();
        START = 1'b0;
        tick();
        X_OUT_ENABLE = 1'b1;
        tick();
        X_OUT_ENABLE = 1'b0;
        tick();
        RST = 1'b1;
        START = 1'b1;
        X_OUT_ENABLE = 1'b1;
        LOAD_ENABLE = 1'b1;
        LOAD_ADDR = 6'd0;
        LOAD_DATA = 64'd77;
        tick();
        RST = 1'b0;
        START = 1'b0;
        X_OUT_ENABLE = 1'b0;
        LOAD_ENABLE = 1'b0;
        chk("rst_mid_ctrl", {READY, BUSY, ERROR, X_IN_ENABLE}, 0);
        chk("rst_mid_x_in", X_IN, 0);
        chk("rst_mid_checksum", checksum, 0);
        tick();
        chk("rst_mid_still_idle", {BUSY, X_IN_ENABLE}, 0);
        stream(4, 1, 0, 0);
        for (int a = 0; a < 64; a++) load(a, {$urandom(), $urandom()});
        for (int n = 0; n < 12; n++) begin
            int sz;
            sz = (n % 5 == 4) ? int'($urandom_range(0, 70)) : int'($urandom_range(1, 64));
            stream(sz, -1, 1'($urandom_range(0, 1)), 0);
        end
        stream(64, -1, 1, 0);
        repeat (2) tick();
        chk("exp_x_drained", 64'(exp_x.size()), 0);
        chk("exp_ev_drained", 64'(exp_ev.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/accelerator_vector_feeder.md
ACCELERATOR_VECTOR_FEEDER -- requirements
Module: accelerator_vector_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, element and size width.
REQ-002 SHALL have parameter ADDR_SIZE, default 6, buffer address width; DEPTH = 2**ADDR_SIZE.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  request to stream one vector.
REQ-006 SHALL have port READY  output  1  one-cycle pulse: vector fully delivered.
REQ-007 SHALL have port BUSY  output  1  high from accepted START until READY cycle inclusive.
REQ-008 SHALL have port ERROR  output  1  one-cycle pulse: START rejected.
REQ-009 SHALL have port SIZE_IN  input  DATA_SIZE  number of elements to stream.
REQ-010 SHALL have port LOAD_ENABLE  input  1  buffer write strobe.
REQ-011 SHALL have port LOAD_ADDR  input  ADDR_SIZE  buffer write address.
REQ-012 SHALL have port LOAD_DATA  input  DATA_SIZE  buffer write data.
REQ-013 SHALL have port X_IN_ENABLE  output  1  one-cycle pulse: X_IN holds a new element for the downstream controller.
REQ-014 SHALL have port X_IN  output  DATA_SIZE  element presented to the downstream controller.
REQ-015 SHALL have port X_OUT_ENABLE  input  1  downstream acknowledge, ready for next element.

Function
REQ-016 SHALL hold a DEPTH x DATA_SIZE buffer; LOAD_ENABLE=1 in IDLE writes LOAD_DATA to LOAD_ADDR at the clock edge; LOAD_ENABLE ignored in any other state.
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT, DONE; all outputs registered.
REQ-018 IDLE: START=1 with 1 <= SIZE_IN <= DEPTH latches SIZE_IN, clears index to 0, moves to SEND; X_IN_ENABLE pulses in the cycle after START.
REQ-019 IDLE: START=1 with SIZE_IN=0 pulses READY in the next cycle, emits no element, stays IDLE.
REQ-020 IDLE: START=1 with SIZE_IN > DEPTH pulses ERROR in the next cycle, no READY, stays IDLE.
REQ-021 SEND: X_IN = buffer[index], X_IN_ENABLE=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: X_IN held stable, X_IN_ENABLE=0; on X_OUT_ENABLE=1, index = size-1 goes to DONE, else index increments and goes to SEND; next X_IN_ENABLE one cycle after the acknowledge.
REQ-023 DONE: READY=1 for one cycle, BUSY=1 in that cycle, then IDLE with BUSY=0.
REQ-024 X_OUT_ENABLE SHALL be ignored outside WAIT, including when coincident with X_IN_ENABLE.
REQ-025 START SHALL be ignored while BUSY; SIZE_IN sampled only on accepted START.
REQ-026 Index SHALL be ADDR_SIZE+1 bits wide so that size = DEPTH does not wrap before completion.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, READY=0, BUSY=0, ERROR=0, X_IN_ENABLE=0, X_IN=0, index=0, latched size=0, regardless of state, including mid-stream.
REQ-028 Buffer contents SHALL NOT be cleared by RST; a vector loaded before reset streams unchanged afterwards.
REQ-029 RST SHALL take priority over START, LOAD_ENABLE and X_OUT_ENABLE in the same cycle.

Configuration
REQ-030 Macro ACCELERATOR_VECTOR_FEEDER_CHECKSUM_EN defined: extra output CHECKSUM (DATA_SIZE) = modulo-2**DATA_SIZE sum of every element emitted with X_IN_ENABLE; cleared on accepted START and on RST; final value valid in the READY cycle and held until next accepted START.
REQ-031 Macro undefined: no CHECKSUM port and no accumulator logic; all other behaviour identical.

Verification
REQ-032 Load buffer[0..3] = 5,6,7,8; START with SIZE_IN=4; ack each element 2 cycles after its X_IN_ENABLE -> X_IN sequence 5,6,7,8, four pulses, READY once, 1 cycle after last ack; CHECKSUM=26 if enabled.
REQ-033 START with SIZE_IN=0 -> READY pulse next cycle, no X_IN_ENABLE; START with SIZE_IN=65 (ADDR_SIZE=6) -> ERROR pulse, no READY, BUSY stays 0.
REQ-034 Load all 64 entries with value = address; SIZE_IN=64, ack in same cycle as each pulse and one cycle later -> ack while X_IN_ENABLE=1 ignored; exactly 64 elements 0..63 then READY.
REQ-035 During stream of SIZE_IN=4, assert START and LOAD_ENABLE (addr 1, data 99) mid-stream -> both ignored, stream completes with original data, buffer[1] unchanged.
REQ-036 Assert RST while in WAIT after element 2 -> all outputs 0 next cycle; restart with SIZE_IN=4 -> full original sequence 5,6,7,8 from index 0.
